// File: rtl/rs_pkg.sv
// Shared GF(256) definitions for the Reed-Solomon single-error corrector.
package rs_pkg;

    typedef logic [7:0] sym_t;

    localparam sym_t GF_POLY  = 8'h1D;
    localparam sym_t GF_ALPHA = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        INV,
        CHECK,
        SEARCH,
        DONE
    } state_e;

    function automatic sym_t gf_mul(sym_t a, sym_t b);
        sym_t p;
        sym_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf256_inv.sv
// GF(256) inverse as a^254; the inverse of zero reads as zero.
module gf256_inv
    import rs_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);

    always_comb begin
        sym_t sq;
        sym_t acc;
        sq  = a_i;
        acc = 8'h01;
        // a^2 * a^4 * ... * a^128 = a^254
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        inv_o = acc;
    end

endmodule

// File: rtl/gf256_mult.sv
// GF(256) multiplier, polynomial product reduced mod x^8+x^4+x^3+x^2+1.
module gf256_mult
    import rs_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = gf_mul(a_i, b_i);

endmodule

// File: rtl/rs_single_corr.sv
// Single-symbol RS corrector: locates X = S1/S0 by stepping alpha^j.
module rs_single_corr
    import rs_pkg::*;
#(
    parameter int N = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_s0,
    input  logic [7:0] i_s1,
    input  logic [7:0] i_s2,
    input  logic [7:0] i_s3,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_err,
    output logic       o_fail,
    output logic [4:0] o_pos,
    output logic [7:0] o_mag
);

    localparam logic [4:0] LAST = 5'(N - 1);

    state_e state_q, state_d;
    sym_t s0_q, s1_q, s2_q, s3_q;
    sym_t s0_d, s1_d, s2_d, s3_d;
    sym_t inv_q, inv_d;
    sym_t x_q, x_d;
    sym_t p_q, p_d;
    logic [4:0] j_q, j_d;
    logic err_q, err_d;
    logic fail_q, fail_d;
    logic [4:0] pos_q, pos_d;
    sym_t mag_q, mag_d;

    sym_t inv_w, x_w, s1x_w, s2x_w, pa_w;

    gf256_inv u_inv (.a_i(s0_q), .inv_o(inv_w));
    gf256_mult u_mx (.a_i(s1_q), .b_i(inv_q), .p_o(x_w));
    gf256_mult u_m1 (.a_i(s1_q), .b_i(x_q), .p_o(s1x_w));
    gf256_mult u_m2 (.a_i(s2_q), .b_i(x_q), .p_o(s2x_w));
    gf256_mult u_ma (.a_i(p_q), .b_i(GF_ALPHA), .p_o(pa_w));

    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        inv_d   = inv_q;
        x_d     = x_q;
        p_d     = p_q;
        j_d     = j_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pos_d   = pos_q;
        mag_d   = mag_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    s0_d    = i_s0;
                    s1_d    = i_s1;
                    s2_d    = i_s2;
                    s3_d    = i_s3;
                    err_d   = 1'b0;
                    fail_d  = 1'b0;
                    pos_d   = '0;
                    mag_d   = '0;
                    state_d = INV;
                end
            end
            INV: begin
                if ((s0_q | s1_q | s2_q | s3_q) == 8'h00) begin
                    state_d = DONE;
                end else if (s0_q == 8'h00) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    inv_d   = inv_w;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                x_d     = x_w;
                p_d     = 8'h01;
                j_d     = '0;
                state_d = SEARCH;
            end
            SEARCH: begin
                // Consistency test runs on the registered X in the first step
                if (j_q == 5'd0 && (s1x_w != s2_q || s2x_w != s3_q)) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else if (p_q == x_q) begin
                    err_d   = 1'b1;
                    pos_d   = LAST - j_q;
                    mag_d   = s0_q;
                    state_d = DONE;
                end else if (j_q == LAST) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    p_d = pa_w;
                    j_d = j_q + 5'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    err_d   = 1'b0;
                    fail_d  = 1'b0;
                    pos_d   = '0;
                    mag_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            inv_q   <= '0;
            x_q     <= '0;
            p_q     <= '0;
            j_q     <= '0;
            err_q   <= 1'b0;
            fail_q  <= 1'b0;
            pos_q   <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            inv_q   <= inv_d;
            x_q     <= x_d;
            p_q     <= p_d;
            j_q     <= j_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pos_q   <= pos_d;
            mag_q   <= mag_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_err   = o_valid & err_q;
    assign o_fail  = o_valid & fail_q & ~err_q;
    assign o_pos   = o_err ? pos_q : 5'd0;
    assign o_mag   = o_err ? mag_q : 8'h00;

endmodule

// File: tb/tb_rs_single_corr.sv
// Directed bench for rs_single_corr with N=32 and N=28 instances.
module tb_rs_single_corr;

    logic clk = 1'b0;
    logic rst;
    logic v32, v28;
    logic rdy;
    logic [7:0] s0, s1, s2, s3;

    logic r32, ov32, e32, f32;
    logic [4:0] p32;
    logic [7:0] m32;
    logic r28, ov28, e28, f28;
    logic [4:0] p28;
    logic [7:0] m28;

    logic sel;
    logic rr, ov, oe, of;
    logic [4:0] op;
    logic [7:0] om;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rs_single_corr #(.N(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(r32),
        .i_s0(s0), .i_s1(s1), .i_s2(s2), .i_s3(s3),
        .o_valid(ov32), .i_ready(rdy), .o_err(e32), .o_fail(f32),
        .o_pos(p32), .o_mag(m32)
    );

    rs_single_corr #(.N(28)) dut28 (
        .i_clk(clk), .i_rst(rst), .i_valid(v28), .o_ready(r28),
        .i_s0(s0), .i_s1(s1), .i_s2(s2), .i_s3(s3),
        .o_valid(ov28), .i_ready(rdy), .o_err(e28), .o_fail(f28),
        .o_pos(p28), .o_mag(m28)
    );

    always_comb begin
        rr = sel ? r28 : r32;
        ov = sel ? ov28 : ov32;
        oe = sel ? e28 : e32;
        of = sel ? f28 : f32;
        op = sel ? p28 : p32;
        om = sel ? m28 : m32;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // e * alpha^n by n repeated alpha steps
    function automatic logic [7:0] xpow(input logic [7:0] e, input int n);
        logic [7:0] r;
        r = e;
        for (int i = 0; i < n; i++)
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
        return r;
    endfunction

    task automatic run(input string tag, input logic which,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input int lat, input logic err, input logic fail,
                       input logic [4:0] pos, input logic [7:0] mag,
                       input logic poke, input logic hold);
        int n;
        sel = which;
        #0;
        chk({tag, ".ready_in"}, rr, 1'b1);
        s0 = a; s1 = b; s2 = c; s3 = d;
        if (which) v28 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; v28 = 1'b0;
        n = 0;
        while (!ov && n < 80) begin
            if (poke && n == 4) begin
                v32 = 1'b1; v28 = 1'b1;
                s0 = 8'hFF; s1 = 8'h11; s2 = 8'h22; s3 = 8'h33;
            end else if (poke && n == 7) begin
                v32 = 1'b0; v28 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        v32 = 1'b0; v28 = 1'b0;
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".err"}, oe, err);
        chk({tag, ".fail"}, of, fail);
        chk({tag, ".pos"}, op, pos);
        chk({tag, ".mag"}, om, mag);
        chk({tag, ".ready_busy"}, rr, 1'b0);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk({tag, ".hold_valid"}, ov, 1'b1);
                chk({tag, ".hold_err"}, oe, err);
                chk({tag, ".hold_pos"}, op, pos);
                chk({tag, ".hold_mag"}, om, mag);
                chk({tag, ".hold_ready"}, rr, 1'b0);
            end
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        chk({tag, ".drop_valid"}, ov, 1'b0);
        chk({tag, ".back_idle"}, rr, 1'b1);
        chk({tag, ".idle_err"}, oe, 1'b0);
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1; v32 = 1'b0; v28 = 1'b0; rdy = 1'b0; sel = 1'b0;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst.valid", ov32, 1'b0);
        chk("rst.ready", r32, 1'b1);
        chk("rst.err", e32, 1'b0);
        chk("rst.fail", f32, 1'b0);
        chk("rst.pos", p32, 5'd0);
        chk("rst.mag", m32, 8'h00);
        chk("rst.ready28", r28, 1'b1);
        @(posedge clk); #1;

        run("last_sym", 1'b0, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
            3, 1'b1, 1'b0, 5'd31, 8'h5A, 1'b0, 1'b1);
        run("first_sym32", 1'b0, 8'h01, xpow(8'h01, 31),
            xpow(8'h01, 62), xpow(8'h01, 93),
            34, 1'b1, 1'b0, 5'd0, 8'h01, 1'b1, 1'b0);
        run("first_sym28", 1'b1, 8'h01, xpow(8'h01, 31),
            xpow(8'h01, 62), xpow(8'h01, 93),
            30, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0);
        run("clean", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00,
            1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        run("s0_zero", 1'b0, 8'h00, 8'h10, 8'h00, 8'h00,
            1, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0);
        run("inconsist", 1'b0, 8'h01, 8'h02, 8'h02, 8'h04,
            3, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0);
        run("pos5_n32", 1'b0, 8'h37, xpow(8'h37, 26),
            xpow(8'h37, 52), xpow(8'h37, 78),
            29, 1'b1, 1'b0, 5'd5, 8'h37, 1'b0, 1'b0);
        run("pos1_n28", 1'b1, 8'h37, xpow(8'h37, 26),
            xpow(8'h37, 52), xpow(8'h37, 78),
            29, 1'b1, 1'b0, 5'd1, 8'h37, 1'b0, 1'b0);
        run("pos17_n28", 1'b1, 8'hC3, xpow(8'hC3, 10),
            xpow(8'hC3, 20), xpow(8'hC3, 30),
            13, 1'b1, 1'b0, 5'd17, 8'hC3, 1'b0, 1'b0);

        sel = 1'b0;
        s0 = 8'h01; s1 = xpow(8'h01, 31);
        s2 = xpow(8'h01, 62); s3 = xpow(8'h01, 93);
        v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("midrst.valid", ov32, 1'b0);
        chk("midrst.ready", r32, 1'b1);
        chk("midrst.err", e32, 1'b0);
        @(posedge clk); #1;
        chk("midrst.ready_next", r32, 1'b1);
        seen = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            if (ov32) seen = 1'b1;
            n++;
        end
        chk("midrst.no_result", seen, 1'b0);

        run("after_rst", 1'b0, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
            3, 1'b1, 1'b0, 5'd31, 8'h5A, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/rs_single_corr.md
RS_SINGLE_CORR -- requirements
Module: rs_single_corr

Interface
REQ-001 SHALL: parameter N, default 32, codeword length in symbols (32 for C1, 28 for C2); legal range 2..32.
REQ-002 SHALL: i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL: i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL: i_valid  input  1  syndrome set valid.
REQ-005 SHALL: o_ready  output  1  block idle, able to accept a syndrome set.
REQ-006 SHALL: i_s0, i_s1, i_s2, i_s3  input  8 each  syndromes S0..S3 (GF(256), poly 0x11D).
REQ-007 SHALL: o_valid  output  1  result valid.
REQ-008 SHALL: i_ready  input  1  downstream accepts result.
REQ-009 SHALL: o_err  output  1  exactly one symbol error located.
REQ-010 SHALL: o_fail  output  1  uncorrectable; caller sets erasure flags.
REQ-011 SHALL: o_pos  output  5  error symbol index, 0 = first received symbol.
REQ-012 SHALL: o_mag  output  8  error magnitude, XOR into symbol o_pos.

Function
REQ-013 SHALL: accept when i_valid && o_ready; S0..S3 are registered on that edge (e0).
REQ-014 SHALL: FSM states IDLE, INV, CHECK, SEARCH, DONE; o_ready = (state==IDLE).
REQ-015 SHALL: on accept, all Sk==0 -> DONE with o_err=0, o_fail=0 (clean word).
REQ-016 SHALL: on accept, S0==0 with any other Sk!=0 -> DONE with o_fail=1.
REQ-017 SHALL: otherwise IDLE -> INV; INV registers inv(S0), one cycle, -> CHECK.
REQ-018 SHALL: CHECK computes X = S1*inv(S0) and registers it; it then tests S1*X==S2 and S2*X==S3. Any mismatch -> DONE with o_fail=1; otherwise -> SEARCH with j=0, P=1.
REQ-019 SHALL: in SEARCH, each cycle compare P==X. On match, -> DONE with o_err=1, o_pos=N-1-j, o_mag=S0. Otherwise P<=P*alpha (alpha=0x02) and j<=j+1.
REQ-020 SHALL: SEARCH with j==N-1 and no match -> DONE with o_fail=1 (locator outside the shortened codeword).
REQ-021 SHALL: latency is fixed as follows.
- Clean word and S0==0 cases: o_valid high after edge e0+1.
- Check fail: o_valid high after e0+3.
- Match at index j: o_valid high after e0+3+j.
- Worst case: e0+2+N.
REQ-022 SHALL: DONE holds o_valid=1 with o_err, o_fail, o_pos and o_mag stable until i_valid-independent i_ready=1; that edge -> IDLE.
REQ-023 SHALL: o_err and o_fail are never both 1; both are 0 whenever o_valid=0.
REQ-024 SHALL: o_pos and o_mag read 0 when o_err=0.
REQ-025 SHALL: i_valid while not o_ready is ignored; syndromes are not re-sampled mid-operation.
REQ-026 SHALL: GF multiply is the polynomial product reduced mod x^8+x^4+x^3+x^2+1; the j counter is 5 bits wide and does not wrap within one search.

Reset
REQ-027 SHALL: i_rst asserted at any time forces state IDLE.
- Outputs: o_valid=0, o_err=0, o_fail=0, o_pos=0, o_mag=0.
- Internal state: S0..S3 registers, inverse, X, P and j cleared.
REQ-028 SHALL: reset mid-SEARCH or mid-DONE discards the operation with no result emitted; o_ready=1 in the first cycle after deassertion.

Structure
REQ-029 SHALL: shared package rs_pkg holds the following.
- GF_POLY = 8'h1D and GF_ALPHA = 8'h02.
- State enum (IDLE, INV, CHECK, SEARCH, DONE).
- Symbol typedef (8-bit).
REQ-030 SHALL: one existing gf256_inv instance computes inv(S0). The GF multiply is instantiated as the existing gf256_mult for S1*inv, S1*X, S2*X and P*alpha; no new sub-module is created.
REQ-031 SHALL: inv(S0) is registered before use, so no combinational path runs from inverse to multiply to compare within one cycle.

Verification
REQ-032 SHALL: S0=S1=S2=S3=0x5A (error at last symbol, X=1), N=32 -> o_err=1, o_pos=31, o_mag=0x5A, o_valid after e0+3.
REQ-033 SHALL: Sk=0x01*alpha^(31k) (error e=0x01 at symbol 0), N=32 -> o_err=1, o_pos=0, o_mag=0x01, o_valid after e0+34. The same stimulus with N=28 -> o_fail=1 after e0+30.
REQ-034 SHALL: S0..S3 all 0 -> o_valid after e0+1 with o_err=0, o_fail=0. S0=0x00, S1=0x10 -> o_fail=1 after e0+1.
REQ-035 SHALL: S0=0x01, S1=0x02, S2=0x02, S3=0x04 (inconsistent) -> o_fail=1 after e0+3.
REQ-036 SHALL: hold i_ready=0 for 5 cycles in DONE -> outputs stable and o_ready=0 throughout. i_rst pulse mid-SEARCH -> o_valid never rises and o_ready=1 next cycle.
